mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage data-memory access unit of the LEGv8 pipelined CPU. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register. Runs every LDUR/LDURSW/LDURH/LDURB/STUR/STURW/STURH/STURB against an external data-memory port with a req/ack handshake, and stalls the pipeline until the access completes. Its `read_data` output feeds the MEM/WB register's `read_data` input.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of REQ cycles without `dmem_ack` before the access is aborted; legal range 1–255.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `memRead`, in, 1: load in MEM this cycle.
- `memWrite`, in, 1: store in MEM this cycle.
- `mem_size`, in, 2: access size; 00 = byte, 01 = half, 10 = word, 11 = double.
- `sign_ext`, in, 1: sign-extend load result (LDURSW); ignored for size 11 and for stores.
- `alu_result`, in, 64: effective byte address.
- `write_data`, in, 64: store data, right-justified.
- `dmem_req`, out, 1: bus request, registered.
- `dmem_we`, out, 1: 1 = write, registered.
- `dmem_addr`, out, 64: doubleword address `{addr[63:3],3'b0}`, registered.
- `dmem_wdata`, out, 64: lane-shifted store data, registered.
- `dmem_wstrb`, out, 8: byte strobes, registered.
- `dmem_rdata`, in, 64: read data, valid when `dmem_ack`=1.
- `dmem_ack`, in, 1: access complete.
- `read_data`, out, 64: extracted/extended load result, registered.
- `mem_stall`, out, 1: freeze PC, IF/ID, ID/EX and EX/MEM; hold MEM/WB.
- `mem_fault`, out, 1: misaligned, illegal, or timed-out access.

## Operation
States: IDLE, REQ, DONE. Reset sets state to IDLE. Reset value of every registered output and of the internal counter is 0. `mem_stall` and `mem_fault` are forced to 0 while `reset_n`=0.

Byte offset is `off = alu_result[2:0]`. Size mask `m` is 0x01, 0x03, 0x0F or 0xFF for sizes 00–11.

An access is misaligned when `off` is not a multiple of the size: half needs `off[0]`=0, word needs `off[1:0]`=0, double needs `off`=0. An access is illegal when `memRead` and `memWrite` are both 1.

IDLE:
- Request present (`memRead|memWrite`), not misaligned, not illegal:
  - capture `dmem_we` = `memWrite`, `dmem_addr`, `dmem_wdata = write_data << 8*off`, `dmem_wstrb = m << off`, plus `off`, size and `sign_ext` for the later read extraction;
  - set `dmem_req` = 1 and go to REQ;
  - `mem_stall` = 1 (combinational).
- Misaligned or illegal:
  - no bus access, stores suppressed, `read_data` unchanged;
  - `mem_fault` = 1 (combinational), `mem_stall` = 0;
  - stay in IDLE.
- No request: `mem_stall` = 0, `read_data` holds its value.
- `dmem_ack` is ignored in IDLE.

REQ:
- `dmem_req` and all `dmem_*` outputs are held stable; `mem_stall` = 1; the counter increments each cycle.
- `dmem_ack` = 1:
  - on a read, `read_data <= ext((dmem_rdata >> 8*off) & mask64(size))`; ext sign-extends from bit 7, 15 or 31 when `sign_ext`=1, otherwise zero-extends;
  - clear `dmem_req` and `dmem_we`, clear the counter, go to DONE.
- No ack when the counter reaches `TIMEOUT`−1:
  - clear `dmem_req` and set the fault flag;
  - `read_data <= 0` (loads only), go to DONE.
- Ack in the same cycle as the timeout wins: normal completion, no fault.

DONE:
- `mem_stall` = 0, so the MEM/WB register captures `read_data` at this edge.
- `mem_fault` = the registered fault flag; the flag clears on leaving DONE.
- Inputs and `dmem_ack` are ignored.
- Next state is always IDLE.

## Timing
- A non-memory instruction passes with 0 stall cycles.
- A memory op with ack in the first REQ cycle takes 3 cycles: IDLE (stall), REQ (stall), DONE (no stall). That is 2 stall cycles.
- Each additional ack wait cycle adds 1 stall cycle. Worst case is `TIMEOUT`+1 stall cycles.
- `read_data` is valid from the DONE cycle and holds until the next completed or timed-out load.
- `dmem_req` rises one cycle after the IDLE request cycle and stays high until the edge on which ack (or timeout) is sampled.
- An asynchronous reset in REQ drops `dmem_req` immediately. A late `dmem_ack` that arrives after reset falls into IDLE and is ignored.
- Back-to-back memory ops: the second is seen in the IDLE cycle right after DONE. There is no bubble beyond the 3-cycle sequence.

## Test plan
- STUR, `alu_result`=0x1000, `write_data`=0x1122334455667788, ack on the first REQ cycle -> `dmem_addr`=0x1000, `dmem_wstrb`=0xFF, `dmem_we`=1; `mem_stall` high for 2 cycles; `read_data` unchanged.
- LDURB at 0x1005 with `dmem_rdata`=0x80_7F_..., byte 5 = 0x9A -> `read_data`=0x000000000000009A. LDURSW at 0x1004 with upper word 0x8000_0001 -> `read_data`=0xFFFFFFFF80000001.
- STURH at 0x1006, `write_data`=0xABCD -> `dmem_wstrb`=0xC0 and `dmem_wdata[63:48]`=0xABCD.
- LDURH at 0x1003 -> `mem_fault`=1 for 1 cycle, `mem_stall`=0, `dmem_req` stays 0. `memRead`=`memWrite`=1 -> same response.
- `TIMEOUT`=4, ack never asserted -> `dmem_req` high for 4 cycles, DONE with `mem_fault`=1 and `read_data`=0. Repeat with ack on the 4th REQ cycle -> no fault, data captured.
- Assert `reset_n`=0 in the second REQ cycle, then ack 2 cycles later -> all outputs 0 at once; the ack is ignored; the next LDUR completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the data memory (slave).
// Request fields are registered in the master and stay stable while dmem_req is high.
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;

    // Handshake: the master raises dmem_req with all fields valid and holds them
    // until the edge on which it samples dmem_ack=1 (or gives up on timeout).
    // dmem_rdata is meaningful only in a cycle where dmem_ack=1.
    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// LEGv8 MEM-stage data-memory access unit: runs loads/stores over a req/ack bus and
// stalls the pipeline until the access completes, faults, or times out.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  mem_size,
    input  logic        sign_ext,
    input  logic [63:0] alu_result,
    input  logic [63:0] write_data,
    mem_access_unit_if.master dmem,
    output logic [63:0] read_data,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [2:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [63:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;

    logic [2:0]  off;
    logic [7:0]  size_mask;
    logic        misaligned;
    logic        illegal;
    logic        access;
    logic [63:0] shifted;
    logic [63:0] load_val;
    logic        stall;
    logic        fault;

    assign off     = alu_result[2:0];
    assign access  = memRead | memWrite;
    assign illegal = memRead & memWrite;

    always_comb begin
        size_mask  = 8'h01;
        misaligned = 1'b0;
        case (mem_size)
            2'b00: begin size_mask = 8'h01; misaligned = 1'b0;       end
            2'b01: begin size_mask = 8'h03; misaligned = off[0];     end
            2'b10: begin size_mask = 8'h0F; misaligned = |off[1:0];  end
            default: begin size_mask = 8'hFF; misaligned = |off;     end
        endcase
    end

    // Lane extraction uses the offset/size captured at request time, not the live inputs.
    always_comb begin
        shifted  = dmem.dmem_rdata >> {off_q, 3'b000};
        load_val = shifted;
        case (size_q)
            2'b00: load_val = sext_q ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
            2'b01: load_val = sext_q ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
            2'b10: load_val = sext_q ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        off_d   = off_q;
        size_d  = size_q;
        sext_d  = sext_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        stall   = 1'b0;
        fault   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !misaligned && !illegal) begin
                    req_d   = 1'b1;
                    we_d    = memWrite;
                    addr_d  = {alu_result[63:3], 3'b000};
                    wdata_d = write_data << {off, 3'b000};
                    wstrb_d = size_mask << off;
                    off_d   = off;
                    size_d  = mem_size;
                    sext_d  = sign_ext;
                    cnt_d   = 8'd0;
                    state_d = REQ;
                    stall   = 1'b1;
                end else if (access) begin
                    fault = 1'b1;
                end
            end
            REQ: begin
                stall = 1'b1;
                // Ack is tested first so a same-cycle ack beats the timeout.
                if (dmem.dmem_ack) begin
                    if (!we_q) rdata_d = load_val;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    if (!we_q) rdata_d = 64'd0;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                fault   = fault_q;
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            wstrb_q <= 8'd0;
            off_q   <= 3'd0;
            size_q  <= 2'd0;
            sext_q  <= 1'b0;
            rdata_q <= 64'd0;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_wstrb = wstrb_q;
    assign read_data       = rdata_q;
    assign mem_stall       = stall & reset_n;
    assign mem_fault       = fault & reset_n;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random load/store traffic against a
// byte-lane reference model, with a queue of expected load results.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic        sign_ext = 1'b0;
  logic [63:0] alu_result = 64'd0;
  logic [63:0] write_data = 64'd0;
  logic [63:0] read_data;
  logic        mem_stall;
  logic        mem_fault;
  logic [1:0]  dbg_state;

  mem_access_unit_if dmem_bus();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .mem_size   (mem_size),
    .sign_ext   (sign_ext),
    .alu_result (alu_result),
    .write_data (write_data),
    .dmem       (dmem_bus),
    .read_data  (read_data),
    .mem_stall  (mem_stall),
    .mem_fault  (mem_fault),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_rd = 64'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: byte-lane arithmetic
  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic logic [7:0] model_strb(input int off, input int nb);
    logic [7:0] r = 8'd0;
    for (int b = 0; b < 8; b++) if (b >= off && b < off + nb) r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] wd, input int off);
    logic [63:0] r = 64'd0;
    for (int b = off; b < 8; b++) r[8*b +: 8] = wd[8*(b-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rd, input int off,
                                             input int nb, input bit sx);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = rd[8*(off+i) +: 8];
    if (sx && nb < 8 && r[8*nb-1]) for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic clear_inputs();
    memRead = 1'b0;
    memWrite = 1'b0;
    mem_size = 2'd0;
    sign_ext = 1'b0;
    alu_result = 64'd0;
    write_data = 64'd0;
  endtask

  // driver: called #1 after a rising edge with the DUT idle; returns likewise
  task automatic do_op(input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] rdat, input int ack_delay);
    int off = int'(addr[2:0]);
    int nb = nbytes(sz);
    bit bad = (rd && wr) || ((rd || wr) && (off % nb != 0));
    bit go = (rd || wr) && !bad;
    int stalls = 0;
    bit acked = 1'b0;
    memRead = rd;
    memWrite = wr;
    mem_size = sz;
    sign_ext = sx;
    alu_result = addr;
    write_data = wd;
    @(negedge clock);
    check("idle_stall", 64'(mem_stall), 64'(go));
    check("idle_fault", 64'(mem_fault), 64'(bad));
    check("idle_req", 64'(dmem_bus.dmem_req), 64'd0);
    if (mem_stall) stalls++;
    @(posedge clock); #1;
    if (!go) begin
      clear_inputs();
      @(negedge clock);
      check("nogo_req", 64'(dmem_bus.dmem_req), 64'd0);
      check("nogo_fault", 64'(mem_fault), 64'd0);
      check("nogo_rdata", read_data, model_rd);
      @(posedge clock); #1;
      return;
    end
    for (int k = 0; k < TO; k++) begin
      dmem_bus.dmem_ack = (k == ack_delay);
      dmem_bus.dmem_rdata = dmem_bus.dmem_ack ? rdat : {$urandom, $urandom};
      @(negedge clock);
      check("req_req", 64'(dmem_bus.dmem_req), 64'd1);
      check("req_we", 64'(dmem_bus.dmem_we), 64'(wr));
      check("req_addr", dmem_bus.dmem_addr, addr & ~64'h7);
      check("req_wstrb", 64'(dmem_bus.dmem_wstrb), 64'(model_strb(off, nb)));
      if (wr) check("req_wdata", dmem_bus.dmem_wdata, model_wdata(wd, off));
      check("req_fault", 64'(mem_fault), 64'd0);
      if (mem_stall) stalls++;
      @(posedge clock); #1;
      if (k == ack_delay) begin
        acked = 1'b1;
        break;
      end
    end
    dmem_bus.dmem_ack = 1'b0;
    clear_inputs();
    if (rd) exp_q.push_back(acked ? model_load(rdat, off, nb, sx) : 64'd0);
    @(negedge clock);
    check("done_stall", 64'(mem_stall), 64'd0);
    check("done_fault", 64'(mem_fault), 64'(!acked));
    check("done_req", 64'(dmem_bus.dmem_req), 64'd0);
    check("stall_cycles", 64'(stalls), acked ? 64'(ack_delay + 2) : 64'(TO + 1));
    if (rd) model_rd = exp_q.pop_front();
    check("done_rdata", read_data, model_rd);
    @(posedge clock); #1;
  endtask

  initial begin
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = 64'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_rdata", read_data, 64'd0);
    check("rst_req", 64'(dmem_bus.dmem_req), 64'd0);
    check("rst_addr", dmem_bus.dmem_addr, 64'd0);
    check("rst_wstrb", 64'(dmem_bus.dmem_wstrb), 64'd0);
    check("rst_stall", 64'(mem_stall), 64'd0);
    check("rst_fault", 64'(mem_fault), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // directed cases
    do_op(0, 1, 2'b11, 0, 64'h1000, 64'h1122334455667788, 64'd0, 0);
    do_op(1, 0, 2'b00, 0, 64'h1005, 64'd0, 64'h807F_9A44_3322_1100, 0);
    check("ldurb_value", read_data, 64'h0000_0000_0000_009A);
    do_op(1, 0, 2'b10, 1, 64'h1004, 64'd0, 64'h8000_0001_DEAD_BEEF, 1);
    check("ldursw_value", read_data, 64'hFFFF_FFFF_8000_0001);
    do_op(0, 1, 2'b01, 0, 64'h1006, 64'hABCD, 64'd0, 2);
    do_op(1, 0, 2'b01, 0, 64'h1003, 64'd0, 64'd0, 0);
    do_op(1, 1, 2'b11, 0, 64'h2000, 64'h55, 64'd0, 0);
    do_op(1, 0, 2'b11, 0, 64'h3000, 64'd0, 64'h0123_4567_89AB_CDEF, 99);
    check("timeout_value", read_data, 64'd0);
    do_op(1, 0, 2'b11, 0, 64'h3008, 64'd0, 64'h0123_4567_89AB_CDEF, TO - 1);
    check("late_ack_value", read_data, 64'h0123_4567_89AB_CDEF);
    do_op(0, 1, 2'b10, 0, 64'h3010, 64'hCAFE_F00D, 64'd0, 99);

    // asynchronous reset during REQ, followed by a stray ack
    memRead = 1'b1;
    mem_size = 2'b11;
    alu_result = 64'h4000;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("arst_req", 64'(dmem_bus.dmem_req), 64'd0);
    check("arst_stall", 64'(mem_stall), 64'd0);
    check("arst_fault", 64'(mem_fault), 64'd0);
    check("arst_rdata", read_data, 64'd0);
    model_rd = 64'd0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    clear_inputs();
    @(posedge clock); #1;
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clock);
    check("stray_ack_req", 64'(dmem_bus.dmem_req), 64'd0);
    check("stray_ack_stall", 64'(mem_stall), 64'd0);
    @(posedge clock); #1;
    dmem_bus.dmem_ack = 1'b0;
    @(negedge clock);
    check("stray_ack_rdata", read_data, 64'd0);
    @(posedge clock); #1;
    do_op(1, 0, 2'b11, 0, 64'h4000, 64'd0, 64'h1357_9BDF_2468_ACE0, 0);

    // random traffic
    for (int n = 0; n < 80; n++) begin
      int kind = $urandom_range(0, 9);
      logic [1:0] sz = 2'($urandom_range(0, 3));
      int nb = nbytes(sz);
      logic [63:0] base = {$urandom, $urandom};
      int off = $urandom_range(0, 7);
      logic [63:0] wd = {$urandom, $urandom};
      logic [63:0] rdat = {$urandom, $urandom};
      bit sx = 1'($urandom_range(0, 1));
      int dly = $urandom_range(0, TO);
      if (kind == 0) begin
        do_op(0, 0, sz, sx, base, wd, rdat, dly);
      end else if (kind == 1) begin
        do_op(1, 1, sz, sx, base, wd, rdat, dly);
      end else if (kind == 2) begin
        if (sz == 2'b00) sz = 2'b11;
        nb = nbytes(sz);
        if (off % nb == 0) off = off + 1;
        do_op(1, 0, sz, sx, {base[63:3], 3'(off)}, wd, rdat, dly);
      end else begin
        off = off - (off % nb);
        do_op(kind < 6, kind >= 6, sz, sx, {base[63:3], 3'(off)}, wd, rdat, dly);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
